// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO read-side streamer.
//   occ_t              - buffer occupancy (0..2 words)
//   FIFO_RD_BUF_DEPTH  - prefetch buffer entries
//   beat_cnt_w()       - width of the accepted-beat counter for a FIFO depth
package fifo_rd_pkg;

    localparam int FIFO_RD_BUF_DEPTH = 2;

    typedef logic [1:0] occ_t;

    function automatic int beat_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry circular prefetch buffer.
//   clk, rstN   - clock, async active-low reset
//   push        - write push_data into the tail entry
//   push_data   - word captured from the FIFO
//   pop         - consumer took the head entry
//   occ         - number of buffered words
//   head_data   - word at the head pointer
// Push and pop in the same cycle leave occ unchanged and advance both
// pointers. The caller guarantees push never happens while full.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [FIFO_RD_BUF_DEPTH];
    logic             head;
    logic             tail;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head <= 1'b0;
            tail <= 1'b0;
            occ  <= '0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            occ <= occ + occ_t'(push) - occ_t'(pop);
        end
    end

    // Storage carries no reset: contents are only observed while occ != 0.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
    end

    assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side master for the synchronous FIFO. Issues rd_en,
// captures the registered FIFO data one cycle later into a 2-entry prefetch
// buffer, and presents the buffer head on a valid/ready stream.
//   clk, rstN  - clock, async active-low reset
//   enable     - permits new FIFO reads
//   rd_en      - FIFO read enable (never while empty)
//   empty      - FIFO empty flag
//   fifo_data  - FIFO data_out, valid the cycle after rd_en
//   m_valid, m_data, m_ready - output stream
//   beat_cnt   - accepted beats, wrapping
//   busy       - words buffered or in flight
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rstN,
    input  logic                                  enable,
    output logic                                  rd_en,
    input  logic                                  empty,
    input  logic [FIFO_WIDTH-1:0]                 fifo_data,
    output logic                                  m_valid,
    output logic [FIFO_WIDTH-1:0]                 m_data,
    input  logic                                  m_ready,
    output logic [beat_cnt_w(FIFO_DEPTH)-1:0]     beat_cnt,
    output logic                                  busy
);

    localparam int BW = beat_cnt_w(FIFO_DEPTH);

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] pending;

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;

    // Credit: words that will sit in the buffer after this edge. A read is
    // issued only if its data will find a free slot one cycle later. Taking
    // pop into account (combinational from m_ready) keeps a full-rate stream
    // from bubbling.
    assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en   = enable & ~empty & (pending <= 3'd1);

    assign busy = m_valid | inflight;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= rd_en;
            if (pop) beat_cnt <= beat_cnt + BW'(1);
        end
    end

    fifo_rd_skid #(
        .WIDTH(FIFO_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rstN     (rstN),
        .push     (inflight),
        .push_data(fifo_data),
        .pop      (pop),
        .occ      (occ),
        .head_data(m_data)
    );

endmodule
